// File: rtl/lcd_string_driver.sv
// rtl/lcd_string_driver.sv - HD44780 4-bit write-only driver that shows a 32-char string on a 16x2 LCD
// Optional LCD_DIRTY_SKIP_EN: refresh requests whose string matches the last one written cause no bus activity.
module lcd_string_driver #(
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_SETUP = 2,
  parameter int T_EHI   = 12,
  parameter int T_NIB   = 50,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic         CCLK,
  input  logic         rst,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         LCDE,
  output logic         LCDRS,
  output logic         LCDRW,
  output logic [3:0]   LCDDAT,
  output logic         busy
);
  localparam logic [19:0] W_PWRUP = (T_PWRUP < 1) ? 20'd1 : 20'(T_PWRUP);
  localparam logic [19:0] W_INIT1 = (T_INIT1 < 1) ? 20'd1 : 20'(T_INIT1);
  localparam logic [19:0] W_INIT2 = (T_INIT2 < 1) ? 20'd1 : 20'(T_INIT2);
  localparam logic [19:0] W_SETUP = (T_SETUP < 1) ? 20'd1 : 20'(T_SETUP);
  localparam logic [19:0] W_EHI   = (T_EHI   < 1) ? 20'd1 : 20'(T_EHI);
  localparam logic [19:0] W_NIB   = (T_NIB   < 1) ? 20'd1 : 20'(T_NIB);
  localparam logic [19:0] W_CMD   = (T_CMD   < 1) ? 20'd1 : 20'(T_CMD);
  localparam logic [19:0] W_CLR   = (T_CLR   < 1) ? 20'd1 : 20'(T_CLR);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_CFG, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2} state_t;
  typedef enum logic [2:0] {P_LOAD, P_SETUP, P_EHI, P_NIB, P_WAIT} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic          second_q, second_d;
  logic          pending_q, pending_d;
  logic [255:0]  shadow_q, shadow_d;
  logic          lcde_q, lcde_d;
  logic          rs_q, rs_d;
  logic [3:0]    dat_q, dat_d;
  logic          busy_q, busy_d;
`ifdef LCD_DIRTY_SKIP_EN
  logic          valid_q, valid_d;
`endif

  logic [7:0]    chars [32];
  logic [7:0]    item_byte;
  logic          item_rs;
  logic          item_single;
  logic          item_last;
  logic [19:0]   item_wait;

  // Decode the byte (or init nibble) currently being sent from state and index.
  always_comb begin
    for (int i = 0; i < 32; i++) chars[i] = shadow_q[255-8*i -: 8];
    item_byte   = 8'h00;
    item_rs     = 1'b0;
    item_single = 1'b0;
    item_last   = 1'b1;
    item_wait   = W_CMD;
    case (state_q)
      S_INIT: begin
        item_single = 1'b1;
        item_byte   = (idx_q == 5'd3) ? 8'h20 : 8'h30;
        item_wait   = (idx_q == 5'd0) ? W_INIT1 : (idx_q == 5'd1) ? W_INIT2 : W_CMD;
        item_last   = (idx_q == 5'd3);
      end
      S_CFG: begin
        case (idx_q[1:0])
          2'd0:    item_byte = 8'h28;
          2'd1:    item_byte = 8'h06;
          2'd2:    item_byte = 8'h0C;
          default: item_byte = 8'h01;
        endcase
        if (idx_q == 5'd3) item_wait = W_CLR;
        item_last = (idx_q == 5'd3);
      end
      S_ADDR1: item_byte = 8'h80;
      S_LINE1: begin
        item_byte = chars[{1'b0, idx_q[3:0]}];
        item_rs   = 1'b1;
        item_last = (idx_q == 5'd15);
      end
      S_ADDR2: item_byte = 8'hC0;
      S_LINE2: begin
        item_byte = chars[{1'b1, idx_q[3:0]}];
        item_rs   = 1'b1;
        item_last = (idx_q == 5'd15);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    second_d  = second_q;
    pending_d = pending_q | cls;
    shadow_d  = shadow_q;
    lcde_d    = lcde_q;
    rs_d      = rs_q;
    dat_d     = dat_q;
`ifdef LCD_DIRTY_SKIP_EN
    valid_d   = valid_q;
`endif
    case (state_q)
      S_PWRUP: begin
        if (cnt_q >= W_PWRUP - 20'd1) begin
          state_d = S_INIT;
          phase_d = P_LOAD;
          cnt_d   = 20'd0;
          idx_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_IDLE: begin
        if (pending_q) begin
          pending_d = cls;
`ifdef LCD_DIRTY_SKIP_EN
          if (!(valid_q && strdata == shadow_q)) begin
            valid_d  = 1'b1;
`else
          begin
`endif
            shadow_d = strdata;
            state_d  = S_ADDR1;
            phase_d  = P_LOAD;
            cnt_d    = 20'd0;
            idx_d    = 5'd0;
            second_d = 1'b0;
          end
        end
      end
      default: begin
        case (phase_q)
          P_LOAD: begin
            rs_d    = item_rs;
            dat_d   = second_q ? item_byte[3:0] : item_byte[7:4];
            phase_d = P_SETUP;
            cnt_d   = 20'd0;
          end
          P_SETUP: begin
            if (cnt_q >= W_SETUP - 20'd1) begin
              lcde_d  = 1'b1;
              phase_d = P_EHI;
              cnt_d   = 20'd0;
            end else cnt_d = cnt_q + 20'd1;
          end
          P_EHI: begin
            if (cnt_q >= W_EHI - 20'd1) begin
              lcde_d   = 1'b0;
              cnt_d    = 20'd0;
              phase_d  = (!item_single && !second_q) ? P_NIB : P_WAIT;
              second_d = !item_single && !second_q;
            end else cnt_d = cnt_q + 20'd1;
          end
          P_NIB: begin
            if (cnt_q >= W_NIB - 20'd1) begin
              phase_d = P_LOAD;
              cnt_d   = 20'd0;
            end else cnt_d = cnt_q + 20'd1;
          end
          default: begin
            if (cnt_q >= item_wait - 20'd1) begin
              phase_d = P_LOAD;
              cnt_d   = 20'd0;
              idx_d   = idx_q + 5'd1;
              if (item_last) begin
                idx_d = 5'd0;
                case (state_q)
                  S_INIT:  state_d = S_CFG;
                  S_ADDR1: state_d = S_LINE1;
                  S_LINE1: state_d = S_ADDR2;
                  S_ADDR2: state_d = S_LINE2;
                  default: state_d = S_IDLE;
                endcase
              end
            end else cnt_d = cnt_q + 20'd1;
          end
        endcase
      end
    endcase
    busy_d = !(state_d == S_IDLE && !pending_d);
`ifdef LCD_DIRTY_SKIP_EN
    // A request that will be skipped next cycle never raises busy.
    if (state_d == S_IDLE && valid_d && strdata == shadow_d) busy_d = 1'b0;
`endif
  end

  always_ff @(posedge CCLK or negedge rst) begin
    if (!rst) begin
      state_q   <= S_PWRUP;
      phase_q   <= P_LOAD;
      cnt_q     <= 20'd0;
      idx_q     <= 5'd0;
      second_q  <= 1'b0;
      pending_q <= 1'b0;
      shadow_q  <= 256'd0;
      lcde_q    <= 1'b0;
      rs_q      <= 1'b0;
      dat_q     <= 4'd0;
      busy_q    <= 1'b1;
`ifdef LCD_DIRTY_SKIP_EN
      valid_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      second_q  <= second_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      lcde_q    <= lcde_d;
      rs_q      <= rs_d;
      dat_q     <= dat_d;
      busy_q    <= busy_d;
`ifdef LCD_DIRTY_SKIP_EN
      valid_q   <= valid_d;
`endif
    end
  end

  assign LCDE   = lcde_q;
  assign LCDRS  = rs_q;
  assign LCDRW  = 1'b0;
  assign LCDDAT = dat_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_lcd_string_driver.sv
// tb/tb_lcd_string_driver.sv - self-checking bench for lcd_string_driver against a pulse-list reference model
`timescale 1ns/1ps
module tb_lcd_string_driver;
  localparam int TP = 100, TI1 = 40, TI2 = 20, TS = 2, TE = 3, TN = 4, TC = 10, TCL = 30;

  logic         CCLK = 1'b0;
  logic         rst = 1'b0;
  logic         cls = 1'b0;
  logic [255:0] strdata = '0;
  logic         LCDE, LCDRS, LCDRW, busy;
  logic [3:0]   LCDDAT;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] got_q [$];
  logic [4:0] exp_q [$];
  logic [7:0] model_chars [32];
  int cyc = 0;
  int fall_cyc = 0;

  lcd_string_driver #(
    .T_PWRUP(TP), .T_INIT1(TI1), .T_INIT2(TI2), .T_SETUP(TS),
    .T_EHI(TE), .T_NIB(TN), .T_CMD(TC), .T_CLR(TCL)
  ) dut (
    .CCLK(CCLK), .rst(rst), .cls(cls), .strdata(strdata),
    .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDDAT(LCDDAT), .busy(busy)
  );

  always #5 CCLK = ~CCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bus monitor: records every enable pulse as {rs,dat} and checks its timing.
  initial begin
    logic prev_e;
    logic [4:0] prev_bus, rise_bus;
    int stable, high;
    prev_e = 1'b0; prev_bus = '0; rise_bus = '0; stable = 0; high = 0;
    forever begin
      @(negedge CCLK);
      cyc++;
      if (!rst) begin
        prev_e = 1'b0; prev_bus = '0; stable = 0; high = 0;
      end else begin
        if ({LCDRS, LCDDAT} !== prev_bus) stable = 1; else stable++;
        if (LCDE && !prev_e) begin
          got_q.push_back({LCDRS, LCDDAT});
          rise_bus = {LCDRS, LCDDAT};
          high = 1;
          check("setup_cycles_ok", 32'(stable - 1 >= TS), 32'd1);
          check("lcdrw", {31'd0, LCDRW}, 32'd0);
        end else if (LCDE) begin
          high++;
        end else if (prev_e) begin
          check("ehi_cycles", high, TE);
          check("held_through_pulse", 32'(stable >= TE + 1), 32'd1);
          fall_cyc = cyc;
        end
        prev_e = LCDE;
        prev_bus = {LCDRS, LCDDAT};
      end
    end
  end

  function automatic void push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endfunction

  function automatic void build_init();
    exp_q.delete();
    exp_q.push_back(5'h03); exp_q.push_back(5'h03);
    exp_q.push_back(5'h03); exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
  endfunction

  function automatic void build_refresh();
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_byte(1'b1, model_chars[i]);
    push_byte(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push_byte(1'b1, model_chars[i]);
  endfunction

  task automatic load_str();
    for (int i = 0; i < 32; i++) strdata[255-8*i -: 8] = model_chars[i];
  endtask

  task automatic rand_chars();
    for (int i = 0; i < 32; i++) model_chars[i] = 8'($urandom_range(32, 126));
  endtask

  task automatic compare_pulses(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pulse%0d", tag, i), {27'd0, got_q[i]}, {27'd0, exp_q[i]});
  endtask

  task automatic pulse_cls();
    @(negedge CCLK); cls = 1'b1;
    @(negedge CCLK); cls = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag, output int seen_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge CCLK); #1; n++;
    end
    seen_cyc = cyc;
    check({tag, "_idle_reached"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_pulses(input int count, input int budget, input string tag);
    int n;
    n = 0;
    while (got_q.size() < count && n < budget) begin
      @(negedge CCLK); #1; n++;
    end
    check({tag, "_pulses_reached"}, 32'(got_q.size() >= count), 32'd1);
  endtask

  task automatic full_refresh(input string tag);
    int t;
    got_q.delete(); exp_q.delete();
    load_str();
    build_refresh();
    pulse_cls();
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    wait_idle(3000, tag, t);
    compare_pulses(tag);
    check({tag, "_busy_after_tcmd"}, t - fall_cyc, TC);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, busy_seen, k;
    string s1, s2;
    s1 = "0123456789abcdef";
    s2 = "f01d01e01m01w01 ";

    rst = 1'b0;
    repeat (3) @(negedge CCLK);
    #1;
    check("rst_lcde", {31'd0, LCDE}, 32'd0);
    check("rst_lcdrs", {31'd0, LCDRS}, 32'd0);
    check("rst_lcdrw", {31'd0, LCDRW}, 32'd0);
    check("rst_lcddat", {28'd0, LCDDAT}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    rst = 1'b1;
    wait_idle(3000, "init", t);
    build_init();
    compare_pulses("init");

    for (int i = 0; i < 16; i++) begin
      model_chars[i] = 8'(s1[i]);
      model_chars[16+i] = 8'(s2[i]);
    end
    full_refresh("directed");
    repeat (60) @(negedge CCLK);
    #1;
    check("quiet_pulses", got_q.size(), 68);
    check("quiet_busy", {31'd0, busy}, 32'd0);

    for (int r = 0; r < 3; r++) begin
      rand_chars();
      full_refresh($sformatf("random%0d", r));
    end

    rand_chars();
    got_q.delete(); exp_q.delete();
    load_str();
    build_refresh();
    pulse_cls();
    wait_pulses(10, 3000, "midref");
    rand_chars();
    load_str();
    build_refresh();
    repeat (3) begin
      pulse_cls();
      repeat (5) @(negedge CCLK);
    end
    wait_idle(6000, "collapse", t);
    compare_pulses("collapse");
    repeat (60) @(negedge CCLK);
    #1;
    check("collapse_no_extra", got_q.size(), 136);

    rand_chars();
    got_q.delete(); exp_q.delete();
    load_str();
    build_refresh();
    pulse_cls();
    wait_pulses(17, 3000, "abort");
    check("abort_lcde_before", {31'd0, LCDE}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_lcde", {31'd0, LCDE}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_lcddat", {28'd0, LCDDAT}, 32'd0);
    while (exp_q.size() > 17) void'(exp_q.pop_back());
    compare_pulses("abort");
    got_q.delete();
    repeat (2) @(negedge CCLK);
    rst = 1'b1;
    wait_idle(3000, "reinit", t);
    build_init();
    compare_pulses("reinit");

    rand_chars();
    full_refresh("first_after_reset");
`ifdef LCD_DIRTY_SKIP_EN
    got_q.delete();
    busy_seen = 0;
    @(negedge CCLK); cls = 1'b1;
    repeat (60) begin
      @(negedge CCLK); cls = 1'b0; #1;
      if (busy) busy_seen++;
    end
    check("skip_pulses", got_q.size(), 0);
    check("skip_busy", busy_seen, 0);
    k = $urandom_range(0, 31);
    model_chars[k] = (model_chars[k] == 8'h41) ? 8'h42 : 8'h41;
    full_refresh("dirty");
`else
    busy_seen = 0;
    k = 0;
    full_refresh("repeat_same");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
